// File: rtl/timer_cmp_cap_if.sv
`timescale 1ns/1ps
// Peripheral-bus bundle for timer_cmp_cap.
// Write side: waddr_i (byte address), data_i (write data), sel_i (byte lanes), we_i (strobe).
// Read side:  raddr_i (byte address), rd_i (strobe), data_o (registered read data).
// master: the bus side driving requests; slave: the timer peripheral.
interface timer_cmp_cap_if;
    logic [7:0]  waddr_i;
    logic [31:0] data_i;
    logic [3:0]  sel_i;
    logic        we_i;
    logic [7:0]  raddr_i;
    logic        rd_i;
    logic [31:0] data_o;

    modport master (
        output waddr_i, data_i, sel_i, we_i, raddr_i, rd_i,
        input  data_o
    );

    modport slave (
        input  waddr_i, data_i, sel_i, we_i, raddr_i, rd_i,
        output data_o
    );
endinterface

// File: rtl/timer_cmp_cap.sv
`timescale 1ns/1ps
// 32-bit general-purpose timer: prescaled up-counter with programmable
// period, PWM compare output pair and edge-selectable input capture.
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   bus         - register bus (slave modport of timer_cmp_cap_if)
//   cmpo_p_o    - registered PWM output, high while CNT < CMP
//   cmpo_n_o    - complement of cmpo_p_o, forced low when disabled
//   cap_i       - asynchronous capture input
//   irq_o       - level interrupt from enabled OVF/CMP/CAP flags
// Registers (offset[4:0]): 0x00 CTRL, 0x04 CNT, 0x08 TOP, 0x0C CMP,
//   0x10 CAP (ro), 0x14 STAT (W1C). Other offsets read 0.
module timer_cmp_cap #(
    parameter int unsigned PSC_W    = 8,
    parameter int unsigned CAP_SYNC = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    timer_cmp_cap_if.slave bus,
    output logic           cmpo_p_o,
    output logic           cmpo_n_o,
    input  logic           cap_i,
    output logic           irq_o
);

    localparam logic [4:0] OFF_CTRL = 5'h00;
    localparam logic [4:0] OFF_CNT  = 5'h04;
    localparam logic [4:0] OFF_TOP  = 5'h08;
    localparam logic [4:0] OFF_CMP  = 5'h0C;
    localparam logic [4:0] OFF_CAP  = 5'h10;
    localparam logic [4:0] OFF_STAT = 5'h14;

    // Writable CTRL bits: [6:0] control/enables, PSC field from bit 8.
    localparam logic [31:0] CTRL_MASK = 32'h0000_007F | (((32'd1 << PSC_W) - 32'd1) << 8);

    function automatic logic [31:0] lane_merge(input logic [31:0] cur,
                                               input logic [31:0] wdat,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = cur;
        for (int unsigned i = 0; i < 4; i++) begin
            if (sel[i]) res[8*i +: 8] = wdat[8*i +: 8];
        end
        return res;
    endfunction

    logic [4:0]          woff;
    logic [4:0]          roff;
    logic                wr_ctrl, wr_cnt, wr_top, wr_cmp, wr_stat;
    logic [31:0]         ctrl_q, cnt_q, top_q, cmp_q, cap_q;
    logic [31:0]         rdata, rdata_q;
    logic [3:0]          stat_q, stat_set, stat_clr;
    logic                en, cap_en, ovf_ie, cmp_ie, cap_ie;
    logic [1:0]          cap_edge;
    logic [PSC_W-1:0]    psc, psc_cnt_q;
    logic                tick;
    logic [31:0]         cnt_inc;
    logic                ovf_set, cmp_set;
    logic [CAP_SYNC-1:0] cap_sync_q;
    logic                cap_s, cap_prev_q, cap_rise, cap_fall, cap_hit, cap_evt_q;
    logic                cmpo_p_q;
    logic                unused;

    // Only offset[4:0] is decoded.
    assign unused = &{1'b0, bus.waddr_i[7:5], bus.raddr_i[7:5]};

    assign woff    = bus.waddr_i[4:0];
    assign roff    = bus.raddr_i[4:0];
    assign wr_ctrl = bus.we_i && (woff == OFF_CTRL);
    assign wr_cnt  = bus.we_i && (woff == OFF_CNT) && (|bus.sel_i);
    assign wr_top  = bus.we_i && (woff == OFF_TOP);
    assign wr_cmp  = bus.we_i && (woff == OFF_CMP);
    assign wr_stat = bus.we_i && (woff == OFF_STAT);

    assign en       = ctrl_q[0];
    assign cap_en   = ctrl_q[1];
    assign cap_edge = ctrl_q[3:2];
    assign ovf_ie   = ctrl_q[4];
    assign cmp_ie   = ctrl_q[5];
    assign cap_ie   = ctrl_q[6];
    assign psc      = ctrl_q[8 +: PSC_W];

    // Prescaler and counter.
    assign tick    = en && (psc_cnt_q == psc);
    assign cnt_inc = (cnt_q == top_q) ? '0 : cnt_q + 32'd1;
    // A CNT write in the same cycle suppresses the tick's flag side effects.
    assign ovf_set = tick && !wr_cnt && (cnt_q == top_q);
    assign cmp_set = tick && !wr_cnt && (cnt_inc == cmp_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_cnt_q <= '0;
        end else if (!en || wr_cnt || tick) begin
            psc_cnt_q <= '0;
        end else begin
            psc_cnt_q <= psc_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (wr_cnt) begin
            cnt_q <= lane_merge(cnt_q, bus.data_i, bus.sel_i);
        end else if (tick) begin
            cnt_q <= cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            top_q  <= '1;
            cmp_q  <= '0;
        end else begin
            if (wr_ctrl) ctrl_q <= lane_merge(ctrl_q, bus.data_i, bus.sel_i) & CTRL_MASK;
            if (wr_top)  top_q  <= lane_merge(top_q, bus.data_i, bus.sel_i);
            if (wr_cmp)  cmp_q  <= lane_merge(cmp_q, bus.data_i, bus.sel_i);
        end
    end

    // Capture path: synchronizer, edge detector, then the qualified edge is
    // registered once so CNT is sampled CAP_SYNC+1 clocks after the first
    // synchronizer stage sees the pin.
    assign cap_s    = cap_sync_q[CAP_SYNC-1];
    assign cap_rise = cap_s && !cap_prev_q;
    assign cap_fall = !cap_s && cap_prev_q;
    assign cap_hit  = cap_en && ((cap_edge[0] && cap_rise) || (cap_edge[1] && cap_fall));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_sync_q <= '0;
            cap_prev_q <= 1'b0;
            cap_evt_q  <= 1'b0;
            cap_q      <= '0;
        end else begin
            cap_sync_q <= CAP_SYNC'({cap_sync_q, cap_i});
            cap_prev_q <= cap_s;
            cap_evt_q  <= cap_hit;
            if (cap_evt_q) cap_q <= cnt_q;
        end
    end

    // Status flags: hardware set takes priority over a same-cycle W1C.
    assign stat_set = {cap_evt_q && stat_q[2], cap_evt_q, cmp_set, ovf_set};
    assign stat_clr = (wr_stat && bus.sel_i[0]) ? bus.data_i[3:0] : 4'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else begin
            stat_q <= (stat_q & ~stat_clr) | stat_set;
        end
    end

    // Compare outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmpo_p_q <= 1'b0;
        end else begin
            cmpo_p_q <= en && (cnt_q < cmp_q);
        end
    end

    assign cmpo_p_o = cmpo_p_q;
    assign cmpo_n_o = en && !cmpo_p_q;
    assign irq_o    = |(stat_q[2:0] & {cap_ie, cmp_ie, ovf_ie});

    // Register read.
    always_comb begin
        rdata = '0;
        case (roff)
            OFF_CTRL: rdata = ctrl_q;
            OFF_CNT:  rdata = cnt_q;
            OFF_TOP:  rdata = top_q;
            OFF_CMP:  rdata = cmp_q;
            OFF_CAP:  rdata = cap_q;
            OFF_STAT: rdata = {28'd0, stat_q};
            default:  rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (bus.rd_i) begin
            rdata_q <= rdata;
        end
    end

    assign bus.data_o = rdata_q;

endmodule

// File: doc/timer_cmp_cap.md
Name: timer_cmp_cap

Overview:
- 32-bit general-purpose timer peripheral on the system peripheral bus.
- Drives the compare outputs TIMER0_CMPO_P/N into the FPIOA output mux and consumes TIMER0_CAPI from the FPIOA input mux.
- Provides a prescaled up-counter with programmable period, PWM compare, edge-selectable input capture, and one level interrupt to the PLIC.

Parameters:
- PSC_W, 8, prescaler divider width in bits.
- CAP_SYNC, 2, number of synchronizer flops on cap_i.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- waddr_i  input  8  write byte address
- data_i  input  32  write data
- sel_i  input  4  byte lane enables
- we_i  input  1  write strobe
- raddr_i  input  8  read byte address
- rd_i  input  1  read strobe
- data_o  output  32  read data, registered
- cmpo_p_o  output  1  compare output (to TIMER0_CMPO_P)
- cmpo_n_o  output  1  complementary compare output (to TIMER0_CMPO_N)
- cap_i  input  1  capture input (from TIMER0_CAPI), asynchronous
- irq_o  output  1  interrupt, level, active-high

Behaviour:
- Clock and reset: one clock domain. rst_n is asynchronous, active-low.

Register map (offset[4:0]). Unmapped offsets read 0 and ignore writes. All writable registers honour sel_i byte lanes.

0x00 CTRL, reset 0:
- [0] EN
- [1] CAP_EN
- [3:2] CAP_EDGE: 00 none, 01 rising, 10 falling, 11 both
- [4] OVF_IE
- [5] CMP_IE
- [6] CAP_IE
- [15:8] PSC

0x04 CNT, reset 0, rw:
- A write loads the counter and clears the prescaler.

0x08 TOP, reset 0xFFFF_FFFF, rw: counter period minus one.

0x0C CMP, reset 0, rw.

0x10 CAP, reset 0, read-only.

0x14 STAT, reset 0:
- [0] OVF, [1] CMP, [2] CAP, [3] OVR
- Write 1 to clear.

Prescaler:
- psc_cnt counts 0..PSC.
- tick = EN & (psc_cnt == PSC), after which psc_cnt wraps to 0.
- PSC = 0 gives a tick every cycle.
- EN = 0 holds psc_cnt at 0 and holds CNT.

Counter:
- On tick, CNT <= (CNT == TOP) ? 0 : CNT + 1.
- The wrap sets OVF.
- If TOP is written below the current CNT, the counter runs up to 0xFFFF_FFFF, wraps to 0 via normal 32-bit increment (no OVF), and then matches TOP.

Compare:
- CMP flag sets on the tick whose next CNT value equals CMP.
- cmpo_p_o is registered: EN ? (CNT < CMP) : 0, computed from the CNT value of the current cycle (one-cycle output latency).
- cmpo_n_o = EN ? ~cmpo_p : 0.
- CMP = 0 gives P constantly low. CMP > TOP gives P constantly high.

Capture:
- cap_i passes through CAP_SYNC flops, then one edge-detect flop.
- On a qualifying edge with CAP_EN = 1: CAP <= CNT; CAP flag set. If CAP was already set, OVR is also set.
- Pin-to-CAP latency is CAP_SYNC + 1 cycles.
- Synchronizer flops reset to 0, so a high input after reset produces a rising edge.

Simultaneous events:
- A hardware flag set and a software W1C of the same bit in the same cycle: the set wins.
- A CNT write and a tick in the same cycle: the write wins (no OVF/CMP from that tick).
- A capture in the same cycle as a CNT write: the pre-write CNT is captured.

Interrupt:
- irq_o = |(STAT[2:0] & {CAP_IE, CMP_IE, OVF_IE}), combinational from registers.
- OVR does not interrupt.

Bus read:
- data_o updates on the clock after rd_i and holds otherwise.
- data_o resets to 0.
- Writes take effect on the clock edge with we_i.

Reset mid-operation:
- All state returns to reset values immediately.
- cmpo_p_o, cmpo_n_o and irq_o go to 0 asynchronously.

Test Plan:
1. TOP=4, PSC=0, EN=1: CNT sequence 0,1,2,3,4,0 at one step per clock. OVF sets on the 4->0 step. With OVF_IE=1, irq_o rises the cycle after. Writing STAT=0x1 clears both.
2. PSC=2, TOP=9, CMP=3: a tick every 3 cycles. cmpo_p_o is high for 9 clocks (CNT 0..2) and low for 21 clocks per 30-clock period. cmpo_n_o is its complement. CMP flag sets on the 2->3 step.
3. CMP=0 gives cmpo_p_o stuck 0; CMP=0x20 with TOP=9 gives cmpo_p_o stuck 1. EN=0 drives both outputs to 0.
4. CAP_EN=1, CAP_EDGE=01: cap_i rises when CNT=100. CAP reads 100 + (CAP_SYNC+1) = 103 at PSC=0, and the CAP flag sets. A second rising edge before clearing sets OVR. A falling edge does not capture. CAP_EDGE=11 captures both edges.
5. Write CNT=0x50 in the same cycle as a TOP-wrap tick: CNT=0x50, no OVF. A W1C of CAP coinciding with a new capture leaves CAP set.
6. Assert rst_n low mid-count with irq_o high: all outputs go to 0 immediately. After release, TOP reads 0xFFFF_FFFF and CTRL reads 0.
